// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing blocks.
// Provides default operand/stream sizing, the SNG state encoding and the
// XNOR-LFSR lockup pattern (all ones), which never appears in a healthy sequence.
package sc_pkg;

  localparam int unsigned DEF_WIDTH      = 7;
  localparam int unsigned DEF_STREAM_LEN = 127;
  localparam int unsigned DEF_CNT_W      = $clog2(DEF_STREAM_LEN + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sng_state_t;

  localparam logic [DEF_WIDTH-1:0] LFSR_LOCKUP = '1;

endpackage

// File: rtl/sc_cmp.sv
// Unsigned less-than comparator shared by the SNGs and the SC MAC.
// Ports: a, b (W-bit unsigned operands) -> lt = (a < b).
module sc_cmp #(
  parameter int unsigned W = 7
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         lt
);

  assign lt = (a < b);

endmodule

// File: rtl/sc_sng_ctrl.sv
// Stochastic number generator control stage.
// Latches an operand over a valid/ready handshake and emits a STREAM_LEN-bit
// unipolar stream, bit = (rn < operand), flagging the final bit.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/ready  operand handshake (in_ready is combinational, high in IDLE)
//   in_value        WIDTH-bit unsigned operand
//   rn              WIDTH-bit LFSR random number, sampled every clock
//   bit_out         registered stochastic bit
//   bit_valid       registered, bit_out belongs to the current stream
//   bit_last        registered, final bit of the stream
//   ones_cnt        ones emitted in the current stream (SC_SNG_ONES_CNT_EN only)
// Build option: define SC_SNG_ONES_CNT_EN to add the ones counter.
module sc_sng_ctrl
  import sc_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned STREAM_LEN = DEF_STREAM_LEN,
  parameter int unsigned CNT_W      = $clog2(STREAM_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_value,
  input  logic [WIDTH-1:0] rn,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             bit_last
`ifdef SC_SNG_ONES_CNT_EN
  ,
  output logic [CNT_W-1:0] ones_cnt
`endif
);

  sng_state_t       state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bit_out_d, bit_valid_d, bit_last_d;
  logic             lt;
  logic             last_c;

  // Stochastic bit: strict less-than, so rn == value_q yields 0.
  sc_cmp #(.W(WIDTH)) u_cmp (
    .a  (rn),
    .b  (value_q),
    .lt (lt)
  );

  assign last_c = (cnt_q == CNT_W'(STREAM_LEN - 1));

  // Next-state and handshake decode.
  always_comb begin
    state_d     = state_q;
    value_d     = value_q;
    cnt_d       = cnt_q;
    bit_out_d   = bit_out;
    bit_valid_d = 1'b0;
    bit_last_d  = 1'b0;
    in_ready    = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          value_d = in_value;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        bit_out_d   = lt;
        bit_valid_d = 1'b1;
        bit_last_d  = last_c;
        cnt_d       = cnt_q + CNT_W'(1);
        if (last_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      value_q   <= '0;
      cnt_q     <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      bit_last  <= 1'b0;
    end else begin
      state_q   <= state_d;
      value_q   <= value_d;
      cnt_q     <= cnt_d;
      bit_out   <= bit_out_d;
      bit_valid <= bit_valid_d;
      bit_last  <= bit_last_d;
    end
  end

`ifdef SC_SNG_ONES_CNT_EN
  logic [CNT_W-1:0] ones_d;

  // Ones counter: cleared on accept, holds after the stream until the next accept.
  always_comb begin
    ones_d = ones_cnt;
    if (state_q == IDLE && in_valid) begin
      ones_d = '0;
    end else if (state_q == RUN && lt) begin
      ones_d = ones_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ones_cnt <= '0;
    else     ones_cnt <= ones_d;
  end
`else
  // Ones are not tracked in this build.
`endif

endmodule
